// File: rtl/md6_tree_scheduler_pkg.sv
// Shared constants for the MD6 tree scheduler: sizes, FSM encodings and level codes.
package md6_tree_scheduler_pkg;

    localparam int W          = 64;
    localparam int BLK_WORDS  = 64;
    localparam int MAX_LEAVES = 4;
    localparam int CV_BITS    = 1024;
    localparam int TIMEOUT    = 4095;
    localparam int MSG_BITS   = BLK_WORDS * W;
    localparam int MSG_AW     = $clog2(MSG_BITS);
    localparam int LEAF_IW    = $clog2(MAX_LEAVES);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD       = 3'd1;
    localparam logic [2:0] ST_LEAF_RUN   = 3'd2;
    localparam logic [2:0] ST_LEAF_STORE = 3'd3;
    localparam logic [2:0] ST_ROOT_RUN   = 3'd4;
    localparam logic [2:0] ST_OUT        = 3'd5;
    localparam logic [2:0] ST_ERR        = 3'd6;

    localparam logic [7:0] LEAF_LEVEL = 8'd1;
    localparam logic [7:0] ROOT_LEVEL = 8'd2;

    // Zero-padding bit count of a leaf block holding wcnt words.
    function automatic logic [15:0] leaf_padding(input logic [6:0] wcnt);
        return 16'(7'(BLK_WORDS) - wcnt) * 16'(W);
    endfunction

endpackage

// File: rtl/md6_block_packer.sv
// Packs 64-bit words into a 4096-bit block, word slot 0 in the most significant bits.
// clr empties the block; clr together with wr starts a new block at slot 0.
module md6_block_packer
    import md6_tree_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                wr,
    input  logic [W-1:0]        wr_data,
    output logic [MSG_BITS-1:0] block,
    output logic [6:0]          wcnt,
    output logic [15:0]         padding
);

    logic [MSG_BITS-1:0] block_q, block_d;
    logic [6:0]          wcnt_q, wcnt_d;
    logic [6:0]          slot;
    logic [MSG_AW-1:0]   base;

    // Next block contents: optional clear, then write the word into the current slot.
    always_comb begin
        block_d = block_q;
        wcnt_d  = wcnt_q;
        slot    = wcnt_q;
        if (clr) begin
            block_d = '0;
            wcnt_d  = '0;
            slot    = '0;
        end
        base = MSG_AW'((BLK_WORDS - 1 - int'(slot)) * W);
        if (wr) begin
            block_d[base +: W] = wr_data;
            wcnt_d             = slot + 7'd1;
        end
    end

    // Block and word-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_q <= '0;
            wcnt_q  <= '0;
        end else begin
            block_q <= block_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign block   = block_q;
    assign wcnt    = wcnt_q;
    assign padding = leaf_padding(wcnt_q);

endmodule

// File: rtl/md6_tree_scheduler.sv
// MD6 two-level tree scheduler: leaf cf runs over 4096-bit blocks, then one root cf
// over the buffered leaf chaining values. A single-block message is its own root.
// Optional macro MD6_CF_TIMEOUT_EN adds a cf_done watchdog that aborts a stuck run.
module md6_tree_scheduler
    import md6_tree_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [W-1:0]        s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic                cf_enable,
    output logic [MSG_BITS-1:0] cf_message,
    output logic [55:0]         cf_index,
    output logic [7:0]          cf_level,
    output logic                cf_z,
    output logic [15:0]         cf_padding_zero,
    output logic [7:0]          cf_index_padd,
    input  logic                cf_done,
    input  logic [CV_BITS-1:0]  cf_C,
    output logic [CV_BITS-1:0]  hash_C,
    output logic                hash_valid,
    input  logic                hash_ready,
    output logic                err
);

    logic [2:0]          state_q, state_d;
    logic [2:0]          leaf_q, leaf_d;
    logic                last_q, last_d;
    logic                z_q, z_d;
    logic                err_q, err_d;
    logic                run_q, run_d;
    logic [CV_BITS-1:0]  cap_q, cap_d;
    logic [CV_BITS-1:0]  hash_q, hash_d;
    logic [CV_BITS-1:0]  cv_q [MAX_LEAVES];
    logic [CV_BITS-1:0]  cv_d [MAX_LEAVES];
`ifdef MD6_CF_TIMEOUT_EN
    logic [11:0]         tmo_q, tmo_d;
`endif

    logic                hs;
    logic                pk_clr, pk_wr;
    logic [MSG_BITS-1:0] pk_block;
    logic [6:0]          pk_wcnt;
    logic [15:0]         pk_padding;
    logic [MSG_BITS-1:0] root_msg;

    md6_block_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (pk_clr),
        .wr      (pk_wr),
        .wr_data (s_data),
        .block   (pk_block),
        .wcnt    (pk_wcnt),
        .padding (pk_padding)
    );

    // Root message: stored leaf CVs high-order first, slots beyond the leaf count zero.
    for (genvar gi = 0; gi < MAX_LEAVES; gi++) begin : g_root
        assign root_msg[(MAX_LEAVES-1-gi)*CV_BITS +: CV_BITS] =
            (leaf_q > 3'(gi)) ? cv_q[gi] : '0;
    end

    // run_q keeps s_ready low while reset is held and for the first cycle after it.
    assign s_ready    = run_q && (state_q == ST_IDLE || state_q == ST_LOAD || state_q == ST_ERR);
    assign hs         = s_valid && s_ready;
    assign hash_valid = (state_q == ST_OUT);
    assign hash_C     = hash_q;
    assign err        = err_q;

    // cf request fields, driven only while a run is active.
    always_comb begin
        cf_enable       = 1'b0;
        cf_message      = '0;
        cf_index        = '0;
        cf_level        = '0;
        cf_z            = 1'b0;
        cf_padding_zero = '0;
        cf_index_padd   = '0;
        case (state_q)
            ST_LEAF_RUN: begin
                cf_enable       = 1'b1;
                cf_message      = pk_block;
                cf_index        = 56'(leaf_q);
                cf_level        = LEAF_LEVEL;
                cf_z            = last_q && (leaf_q == 3'd0);
                cf_padding_zero = pk_padding;
                cf_index_padd   = last_q ? 8'(leaf_q) : 8'd0;
            end
            ST_ROOT_RUN: begin
                cf_enable       = 1'b1;
                cf_message      = root_msg;
                cf_level        = ROOT_LEVEL;
                cf_z            = 1'b1;
                cf_padding_zero = 16'(3'(MAX_LEAVES) - leaf_q) * 16'(CV_BITS);
                cf_index_padd   = 8'(leaf_q - 3'd1);
            end
            default: ;
        endcase
    end

    // Scheduler FSM: word intake, leaf runs, CV buffering, root run and result handoff.
    always_comb begin
        state_d = state_q;
        leaf_d  = leaf_q;
        last_d  = last_q;
        z_d     = z_q;
        err_d   = err_q;
        run_d   = 1'b1;
        cap_d   = cap_q;
        hash_d  = hash_q;
        cv_d    = cv_q;
        pk_clr  = 1'b0;
        pk_wr   = 1'b0;
        case (state_q)
            ST_IDLE: if (hs) begin
                pk_clr  = 1'b1;
                pk_wr   = 1'b1;
                leaf_d  = '0;
                last_d  = s_last;
                err_d   = 1'b0;
                state_d = s_last ? ST_LEAF_RUN : ST_LOAD;
            end
            ST_LOAD: if (hs) begin
                if (leaf_q == 3'(MAX_LEAVES)) begin
                    // Tree is full and the message keeps going: abort and drain.
                    err_d   = 1'b1;
                    state_d = s_last ? ST_IDLE : ST_ERR;
                end else begin
                    pk_wr  = 1'b1;
                    last_d = s_last;
                    if (s_last || pk_wcnt == 7'(BLK_WORDS - 1))
                        state_d = ST_LEAF_RUN;
                end
            end
            ST_LEAF_RUN: if (cf_done) begin
                cap_d   = cf_C;
                z_d     = cf_z;
                state_d = ST_LEAF_STORE;
            end
            ST_LEAF_STORE: begin
                if (z_q) begin
                    hash_d  = cap_q;
                    state_d = ST_OUT;
                end else begin
                    cv_d[leaf_q[LEAF_IW-1:0]] = cap_q;
                    leaf_d  = leaf_q + 3'd1;
                    pk_clr  = 1'b1;
                    state_d = last_q ? ST_ROOT_RUN : ST_LOAD;
                end
            end
            ST_ROOT_RUN: if (cf_done) begin
                hash_d  = cf_C;
                state_d = ST_OUT;
            end
            ST_OUT: if (hash_ready) state_d = ST_IDLE;
            ST_ERR: if (hs && s_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef MD6_CF_TIMEOUT_EN
        tmo_d = '0;
        if (cf_enable && !cf_done) begin
            if (tmo_q == 12'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = last_q ? ST_IDLE : ST_ERR;
            end else begin
                tmo_d = tmo_q + 12'd1;
            end
        end
`endif
    end

    // State, counters and CV storage; reset drops any run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            leaf_q  <= '0;
            last_q  <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
            cap_q   <= '0;
            hash_q  <= '0;
            for (int i = 0; i < MAX_LEAVES; i++) cv_q[i] <= '0;
`ifdef MD6_CF_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            leaf_q  <= leaf_d;
            last_q  <= last_d;
            z_q     <= z_d;
            err_q   <= err_d;
            run_q   <= run_d;
            cap_q   <= cap_d;
            hash_q  <= hash_d;
            for (int i = 0; i < MAX_LEAVES; i++) cv_q[i] <= cv_d[i];
`ifdef MD6_CF_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule
